// File: rtl/fu_issue_scheduler.sv
// Oldest-first dual-issue scheduler for the unified issue queue.
// Tracks occupancy, FU class and relative age of each RS entry, and each
// cycle registers up to two grants (entry index + FU number).
module fu_issue_scheduler #(
    parameter int RS_SIZE  = 16,
    parameter int IDX_SIZE = 4,
    parameter int FU_SIZE  = 2,
    parameter int FU_ARRAY = 3,
    parameter int LSU_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [IDX_SIZE-1:0] alloc_idx,
    input  logic                alloc_cls,
    input  logic [RS_SIZE-1:0]  req_vec,
    input  logic [FU_ARRAY-1:0] fu_ready_in,
    input  logic                flush,
    output logic                grant_valid1,
    output logic [IDX_SIZE-1:0] grant_idx1,
    output logic [FU_SIZE-1:0]  fu_number_out1,
    output logic                grant_valid2,
    output logic [IDX_SIZE-1:0] grant_idx2,
    output logic [FU_SIZE-1:0]  fu_number_out2,
    output logic [RS_SIZE-1:0]  entry_valid,
    output logic                alloc_err
);

    localparam int CNT_W = (LSU_LAT > 1) ? $clog2(LSU_LAT) : 1;

    logic [RS_SIZE-1:0]              valid_q, valid_d;
    logic [RS_SIZE-1:0]              cls_q, cls_d;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;
    logic [CNT_W-1:0]                lsu_cnt_q, lsu_cnt_d;
    logic                            alloc_err_q, alloc_err_d;
    logic                            grant_valid1_q, grant_valid1_d;
    logic                            grant_valid2_q, grant_valid2_d;
    logic [IDX_SIZE-1:0]             grant_idx1_q, grant_idx1_d;
    logic [IDX_SIZE-1:0]             grant_idx2_q, grant_idx2_d;
    logic [FU_SIZE-1:0]              fu_number1_q, fu_number1_d;
    logic [FU_SIZE-1:0]              fu_number2_q, fu_number2_d;

    logic [RS_SIZE-1:0]  cand, elig1, elig2, issued;
    logic [IDX_SIZE:0]   pick1, pick2;
    logic                alu_avail, lsu_avail;
    logic                alu0_left, alu1_left, lsu_left;
    logic                s1_valid, s2_valid;
    logic [IDX_SIZE-1:0] s1_idx, s2_idx;
    logic [FU_SIZE-1:0]  s1_fu, s2_fu;

    // Entry i wins if no other eligible entry is older than it.
    function automatic logic [IDX_SIZE:0] pick_oldest(
        input logic [RS_SIZE-1:0]              elig,
        input logic [RS_SIZE-1:0][RS_SIZE-1:0] age
    );
        logic [IDX_SIZE:0] res;
        logic              beaten;
        res = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            beaten = 1'b0;
            for (int unsigned j = 0; j < RS_SIZE; j++) begin
                if (j != i && elig[j] && age[j][i]) beaten = 1'b1;
            end
            if (elig[i] && !beaten) res = {1'b1, IDX_SIZE'(i)};
        end
        return res;
    endfunction

    // Candidate selection for both issue slots from current state.
    always_comb begin
        cand      = valid_q & req_vec;
        alu_avail = fu_ready_in[0] | fu_ready_in[1];
        lsu_avail = fu_ready_in[2] && (lsu_cnt_q == '0);

        for (int unsigned i = 0; i < RS_SIZE; i++)
            elig1[i] = cand[i] && (cls_q[i] ? lsu_avail : alu_avail);
        pick1    = pick_oldest(elig1, older_q);
        s1_valid = pick1[IDX_SIZE];
        s1_idx   = pick1[IDX_SIZE-1:0];
        if (!s1_valid)          s1_fu = '0;
        else if (cls_q[s1_idx]) s1_fu = FU_SIZE'(2);
        else                    s1_fu = fu_ready_in[0] ? FU_SIZE'(0) : FU_SIZE'(1);

        alu0_left = fu_ready_in[0] && !(s1_valid && s1_fu == FU_SIZE'(0));
        alu1_left = fu_ready_in[1] && !(s1_valid && s1_fu == FU_SIZE'(1));
        lsu_left  = lsu_avail      && !(s1_valid && s1_fu == FU_SIZE'(2));

        for (int unsigned i = 0; i < RS_SIZE; i++)
            elig2[i] = cand[i] && !(s1_valid && s1_idx == IDX_SIZE'(i)) &&
                       (cls_q[i] ? lsu_left : (alu0_left || alu1_left));
        pick2    = pick_oldest(elig2, older_q);
        s2_valid = pick2[IDX_SIZE];
        s2_idx   = pick2[IDX_SIZE-1:0];
        if (!s2_valid)          s2_fu = '0;
        else if (cls_q[s2_idx]) s2_fu = FU_SIZE'(2);
        else                    s2_fu = alu0_left ? FU_SIZE'(0) : FU_SIZE'(1);

        issued = '0;
        if (s1_valid) issued[s1_idx] = 1'b1;
        if (s2_valid) issued[s2_idx] = 1'b1;
    end

    // Next-state: retire issued entries, LSU lockout, allocation, flush.
    always_comb begin
        valid_d        = valid_q & ~issued;
        cls_d          = cls_q;
        older_d        = older_q;
        alloc_err_d    = alloc_err_q;
        lsu_cnt_d      = (lsu_cnt_q != '0) ? lsu_cnt_q - CNT_W'(1) : '0;
        grant_valid1_d = s1_valid;
        grant_idx1_d   = s1_idx;
        fu_number1_d   = s1_fu;
        grant_valid2_d = s2_valid;
        grant_idx2_d   = s2_idx;
        fu_number2_d   = s2_fu;

        if ((s1_valid && s1_fu == FU_SIZE'(2)) || (s2_valid && s2_fu == FU_SIZE'(2)))
            lsu_cnt_d = CNT_W'(LSU_LAT - 1);

        // An entry issuing this cycle may be reallocated; the new entry wins.
        if (alloc_valid) begin
            if (valid_q[alloc_idx] && !issued[alloc_idx]) begin
                alloc_err_d = 1'b1;
            end else begin
                valid_d[alloc_idx] = 1'b1;
                cls_d[alloc_idx]   = alloc_cls;
                older_d[alloc_idx] = '0;
                for (int unsigned j = 0; j < RS_SIZE; j++)
                    if (j != 32'(alloc_idx) && valid_d[j]) older_d[j][alloc_idx] = 1'b1;
            end
        end

        // Flush drops everything but keeps the LSU lockout running down.
        if (flush) begin
            valid_d        = '0;
            cls_d          = cls_q;
            older_d        = older_q;
            alloc_err_d    = alloc_err_q;
            lsu_cnt_d      = (lsu_cnt_q != '0) ? lsu_cnt_q - CNT_W'(1) : '0;
            grant_valid1_d = 1'b0;
            grant_idx1_d   = '0;
            fu_number1_d   = '0;
            grant_valid2_d = 1'b0;
            grant_idx2_d   = '0;
            fu_number2_d   = '0;
        end
    end

    // State and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            cls_q          <= '0;
            older_q        <= '0;
            lsu_cnt_q      <= '0;
            alloc_err_q    <= 1'b0;
            grant_valid1_q <= 1'b0;
            grant_idx1_q   <= '0;
            fu_number1_q   <= '0;
            grant_valid2_q <= 1'b0;
            grant_idx2_q   <= '0;
            fu_number2_q   <= '0;
        end else begin
            valid_q        <= valid_d;
            cls_q          <= cls_d;
            older_q        <= older_d;
            lsu_cnt_q      <= lsu_cnt_d;
            alloc_err_q    <= alloc_err_d;
            grant_valid1_q <= grant_valid1_d;
            grant_idx1_q   <= grant_idx1_d;
            fu_number1_q   <= fu_number1_d;
            grant_valid2_q <= grant_valid2_d;
            grant_idx2_q   <= grant_idx2_d;
            fu_number2_q   <= fu_number2_d;
        end
    end

    assign grant_valid1   = grant_valid1_q;
    assign grant_idx1     = grant_idx1_q;
    assign fu_number_out1 = fu_number1_q;
    assign grant_valid2   = grant_valid2_q;
    assign grant_idx2     = grant_idx2_q;
    assign fu_number_out2 = fu_number2_q;
    assign entry_valid    = valid_q;
    assign alloc_err      = alloc_err_q;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler: expected grants are queued when a
// cycle is driven and compared after the edge that produces them.
module tb_fu_issue_scheduler;

    localparam int RS_SIZE  = 16;
    localparam int IDX_SIZE = 4;
    localparam int FU_SIZE  = 2;
    localparam int FU_ARRAY = 3;
    localparam int LSU_LAT  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                alloc_valid;
    logic [IDX_SIZE-1:0] alloc_idx;
    logic                alloc_cls;
    logic [RS_SIZE-1:0]  req_vec;
    logic [FU_ARRAY-1:0] fu_ready_in;
    logic                flush;
    logic                grant_valid1, grant_valid2;
    logic [IDX_SIZE-1:0] grant_idx1, grant_idx2;
    logic [FU_SIZE-1:0]  fu_number_out1, fu_number_out2;
    logic [RS_SIZE-1:0]  entry_valid;
    logic                alloc_err;

    always #5 clk = ~clk;

    fu_issue_scheduler #(
        .RS_SIZE (RS_SIZE),
        .IDX_SIZE(IDX_SIZE),
        .FU_SIZE (FU_SIZE),
        .FU_ARRAY(FU_ARRAY),
        .LSU_LAT (LSU_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_idx     (alloc_idx),
        .alloc_cls     (alloc_cls),
        .req_vec       (req_vec),
        .fu_ready_in   (fu_ready_in),
        .flush         (flush),
        .grant_valid1  (grant_valid1),
        .grant_idx1    (grant_idx1),
        .fu_number_out1(fu_number_out1),
        .grant_valid2  (grant_valid2),
        .grant_idx2    (grant_idx2),
        .fu_number_out2(fu_number_out2),
        .entry_valid   (entry_valid),
        .alloc_err     (alloc_err)
    );

    typedef struct packed {
        logic                v1;
        logic [IDX_SIZE-1:0] i1;
        logic [FU_SIZE-1:0]  f1;
        logic                v2;
        logic [IDX_SIZE-1:0] i2;
        logic [FU_SIZE-1:0]  f2;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam exp_t NONE = '0;

    function automatic exp_t one(input logic [IDX_SIZE-1:0] i, input logic [FU_SIZE-1:0] f);
        exp_t e;
        e    = '0;
        e.v1 = 1'b1;
        e.i1 = i;
        e.f1 = f;
        return e;
    endfunction

    function automatic exp_t two(input logic [IDX_SIZE-1:0] i1, input logic [FU_SIZE-1:0] f1,
                                 input logic [IDX_SIZE-1:0] i2, input logic [FU_SIZE-1:0] f2);
        exp_t e;
        e    = one(i1, f1);
        e.v2 = 1'b1;
        e.i2 = i2;
        e.f2 = f2;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected grant, step one edge, then pop and compare.
    task automatic cyc(input exp_t e, input string tag);
        exp_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({tag, ".v1"}, 32'(grant_valid1),   32'(x.v1));
        check({tag, ".i1"}, 32'(grant_idx1),     32'(x.i1));
        check({tag, ".f1"}, 32'(fu_number_out1), 32'(x.f1));
        check({tag, ".v2"}, 32'(grant_valid2),   32'(x.v2));
        check({tag, ".i2"}, 32'(grant_idx2),     32'(x.i2));
        check({tag, ".f2"}, 32'(fu_number_out2), 32'(x.f2));
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        alloc_cls   = 1'b0;
        req_vec     = '0;
        fu_ready_in = '0;
        flush       = 1'b0;
    endtask

    task automatic do_alloc(input logic [IDX_SIZE-1:0] idx, input logic c, input string tag);
        alloc_valid = 1'b1;
        alloc_idx   = idx;
        alloc_cls   = c;
        cyc(NONE, tag);
        alloc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            alloc_valid = 1'($urandom);
            alloc_idx   = IDX_SIZE'($urandom);
            alloc_cls   = 1'($urandom);
            req_vec     = RS_SIZE'($urandom);
            fu_ready_in = FU_ARRAY'($urandom);
            flush       = 1'($urandom);
            cyc(NONE, "reset");
        end
        check("reset.entry_valid", 32'(entry_valid), 32'h0);
        check("reset.alloc_err",   32'(alloc_err),   32'h0);
        rst = 1'b0;
        idle();

        // Dual issue in age order
        do_alloc(4'd5, 1'b0, "t2.alloc5");
        do_alloc(4'd2, 1'b0, "t2.alloc2");
        do_alloc(4'd9, 1'b1, "t2.alloc9");
        check("t2.entry_valid", 32'(entry_valid), 32'h0224);
        req_vec     = 16'h0224;
        fu_ready_in = 3'b111;
        cyc(two(4'd5, 2'd0, 4'd2, 2'd1), "t2.dual");
        cyc(one(4'd9, 2'd2), "t2.lsu");
        idle();
        check("t2.drained", 32'(entry_valid), 32'h0);

        // FU blocking
        do_alloc(4'd3, 1'b0, "t3.alloc3");
        do_alloc(4'd7, 1'b1, "t3.alloc7");
        req_vec     = 16'h0088;
        fu_ready_in = 3'b100;
        cyc(one(4'd7, 2'd2), "t3.lsu_only");
        check("t3.keep3", 32'(entry_valid), 32'h0008);
        fu_ready_in = 3'b010;
        cyc(one(4'd3, 2'd1), "t3.alu1");
        idle();
        check("t3.drained", 32'(entry_valid), 32'h0);

        // LSU lockout
        do_alloc(4'd1, 1'b1, "t4.alloc1");
        do_alloc(4'd4, 1'b1, "t4.alloc4");
        req_vec     = 16'h0012;
        fu_ready_in = 3'b111;
        cyc(one(4'd1, 2'd2), "t4.t0");
        cyc(NONE,            "t4.t1");
        cyc(one(4'd4, 2'd2), "t4.t2");
        idle();

        // No FU ready, then req bits of invalid entries ignored
        do_alloc(4'd0, 1'b0, "bnd.alloc0");
        req_vec     = 16'h0001;
        fu_ready_in = 3'b000;
        cyc(NONE, "bnd.nofu0");
        cyc(NONE, "bnd.nofu1");
        check("bnd.retained", 32'(entry_valid), 32'h0001);
        req_vec     = '1;
        fu_ready_in = 3'b111;
        cyc(one(4'd0, 2'd0), "bnd.ignore_invalid");
        idle();
        check("bnd.drained", 32'(entry_valid), 32'h0);

        // Same-cycle issue and reallocation of idx8
        do_alloc(4'd6,  1'b0, "t6.alloc6");
        do_alloc(4'd11, 1'b0, "t6.alloc11");
        do_alloc(4'd8,  1'b0, "t6.alloc8");
        req_vec     = 16'h0100;
        fu_ready_in = 3'b001;
        alloc_valid = 1'b1;
        alloc_idx   = 4'd8;
        alloc_cls   = 1'b1;
        cyc(one(4'd8, 2'd0), "t6.issue_realloc");
        idle();
        check("t6.entry_valid", 32'(entry_valid), 32'h0940);
        check("t6.no_err",      32'(alloc_err),   32'h0);
        req_vec     = 16'h0940;
        fu_ready_in = 3'b111;
        cyc(two(4'd6, 2'd0, 4'd11, 2'd1), "t6.age");
        cyc(one(4'd8, 2'd2), "t6.cls_lsu");
        idle();
        check("t6.drained", 32'(entry_valid), 32'h0);

        // Flush and alloc error
        do_alloc(4'd10, 1'b0, "t5.alloc10");
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_idx   = 4'd6;
        alloc_cls   = 1'b0;
        cyc(NONE, "t5.flush");
        idle();
        check("t5.flushed", 32'(entry_valid), 32'h0);
        do_alloc(4'd6, 1'b0, "t5.first");
        check("t5.err_clear", 32'(alloc_err), 32'h0);
        do_alloc(4'd6, 1'b1, "t5.second");
        check("t5.err_set",  32'(alloc_err),   32'h1);
        check("t5.keep6",    32'(entry_valid), 32'h0040);
        cyc(NONE, "t5.hold");
        flush = 1'b1;
        cyc(NONE, "t5.flush2");
        flush = 1'b0;
        check("t5.err_sticky", 32'(alloc_err), 32'h1);

        // Reset clears the sticky error
        rst = 1'b1;
        cyc(NONE, "rst2");
        rst = 1'b0;
        check("rst2.alloc_err",   32'(alloc_err),   32'h0);
        check("rst2.entry_valid", 32'(entry_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fu_issue_scheduler.md
Name: fu_issue_scheduler

Overview:
- Oldest-first issue scheduler for the unified issue queue (16 RS entries, 3 FUs: FU0 = ALU0, FU1 = ALU1, FU2 = LSU).
- Tracks occupancy, FU class and relative age of every RS entry.
- Each cycle, picks up to two operand-ready entries whose required FU can accept them, and emits registered grants (entry index + FU number) on two issue slots.
- Sits between dispatch/rename (allocation), the UIQ wakeup logic (ready vector) and the FU bank (fu_ready_in).

Parameters:
- RS_SIZE, 16, number of RS entries
- IDX_SIZE, 4, entry index width (log2 RS_SIZE)
- FU_SIZE, 2, FU number width
- FU_ARRAY, 3, number of FUs
- LSU_LAT, 2, cycles between successive FU2 grants (LSU not pipelined); must be at least 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  1  allocate an entry this cycle
- alloc_idx  in  IDX_SIZE  entry being allocated
- alloc_cls  in  1  required FU class: 0 = ALU (FU0 or FU1), 1 = LSU (FU2)
- req_vec  in  RS_SIZE  bit i = entry i has all operands ready
- fu_ready_in  in  FU_ARRAY  bit f = FU f can accept an instruction this cycle
- flush  in  1  discard all entries (mispredict recovery)
- grant_valid1  out  1  slot 1 issues this cycle
- grant_idx1  out  IDX_SIZE  slot 1 entry index
- fu_number_out1  out  FU_SIZE  slot 1 FU number
- grant_valid2  out  1  slot 2 issues this cycle
- grant_idx2  out  IDX_SIZE  slot 2 entry index
- fu_number_out2  out  FU_SIZE  slot 2 FU number
- entry_valid  out  RS_SIZE  occupancy vector (UIQ uses it for stall/free-list)
- alloc_err  out  1  sticky: allocation targeted an occupied entry

Behaviour:

State:
- valid[RS_SIZE]: occupancy per entry.
- cls[RS_SIZE]: FU class per entry.
- Age matrix older[i][j]: i is older than j.
- lsu_cnt: FU2 lockout down-counter.

Reset:
- rst high at an edge clears all state, lsu_cnt, alloc_err and all outputs (grant_valid*, grant_idx*, fu_number_out* = 0; entry_valid = 0).
- Reset mid-operation drops all pending entries; there is no partial completion.

Candidate selection (combinational from current state; results registered, so latency = 1 cycle from req_vec/fu_ready_in to grant outputs):
- cand[i] = valid[i] & req_vec[i].
- ALU available if fu_ready_in[0] or fu_ready_in[1]. FU2 available if fu_ready_in[2] and lsu_cnt == 0.

Slot 1:
- Takes the oldest cand whose class has an available FU.
- An ALU entry takes the lowest-numbered ready ALU FU.

Slot 2:
- Takes the oldest remaining cand whose class still has an available FU after slot 1's assignment.
- Never the same entry and never the same FU as slot 1.

Grant outputs:
- No eligible entry: grant_valid = 0, and idx/fu_number hold 0.
- Slot 1 is always filled before slot 2; grant_valid2 = 1 implies grant_valid1 = 1.

Update at edge (priority: rst > flush > normal):
- Issued entries: valid cleared.
- LSU grant: lsu_cnt loads LSU_LAT-1; otherwise lsu_cnt decrements while nonzero.
- Alloc: valid[a] = 1, cls[a] = alloc_cls, older[a][*] = 0, older[j][a] = 1 for every j still valid after this edge.
- Alloc to an entry issued the same cycle is legal: the new entry wins.
- Alloc to an entry valid and not issued this cycle: ignored, alloc_err set until rst.
- flush: clears valid and grant_valid1/2 at the edge, and ignores a same-cycle alloc. lsu_cnt is unaffected, because the in-flight LSU op still occupies the unit.

Boundary conditions:
- All 16 entries valid: entry_valid = all ones; dispatch must not allocate.
- All FU ready bits 0: no grants; entries retained.
- req_vec bits for invalid entries are ignored.

Test Plan:
1. Reset: rst = 1 for 2 cycles with random inputs -> all grant outputs 0, entry_valid = 16'h0000, alloc_err = 0.
2. Dual issue, age order: allocate idx5 (ALU), idx2 (ALU), idx9 (LSU) on consecutive cycles; then req_vec bits 5/2/9 = 1, fu_ready_in = 3'b111.
   - Next cycle: slot1 = idx5/FU0, slot2 = idx2/FU1.
   - Following cycle: slot1 = idx9/FU2, grant_valid2 = 0.
3. FU blocking: entries idx3 (ALU, older) and idx7 (LSU), both ready, fu_ready_in = 3'b100.
   - Expect slot1 = idx7/FU2, grant_valid2 = 0, entry_valid[3] still 1.
   - Then fu_ready_in = 3'b010 -> idx3 on FU1.
4. LSU lockout: LSU entries idx1 (older) and idx4 ready, fu_ready_in = 3'b111, LSU_LAT = 2.
   - Expect idx1/FU2 at cycle t, no FU2 grant at t+1, idx4/FU2 at t+2.
5. Flush and alloc error:
   - Flush asserted with alloc_valid = 1 for idx6 -> entry_valid = 0 next cycle.
   - Allocate idx6 twice without issue -> alloc_err = 1 and stays 1 until rst.
6. Same-cycle issue and re-alloc: idx8 granted while alloc_idx = 8 (LSU) -> entry_valid[8] = 1, cls[8] = LSU, and idx8 is younger than all other valid entries.
